// File: rtl/shift_sub_divider.sv
// Sequential restoring divider, one quotient bit per falling clock edge, start/busy/done handshake.
// Define SHIFT_SUB_DIVIDER_SIGNED_EN for two's-complement operands (truncating toward zero).
module shift_sub_divider #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [M-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_q,
  output logic [M-1:0] o_r,
  output logic         o_dbz
);

  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state;
  logic [N-1:0]    r_qsh;
  logic [M-1:0]    r_d;
  logic [M:0]      r_rem;
  logic [CntW-1:0] r_cnt;

  logic [N-1:0]    w_a_mag;
  logic [M-1:0]    w_b_mag;
  logic [M:0]      w_rem_sh;
  logic            w_ge;
  logic [M:0]      w_rem_nx;
  logic [N-1:0]    w_q_nx;
  logic [N-1:0]    w_q_fin;
  logic [M-1:0]    w_r_fin;
  logic            w_unused_rem_msb;

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  // Magnitudes feed the unsigned core; the most-negative values map onto their unsigned bit pattern.
  assign w_a_mag = i_a[N-1] ? (~i_a + N'(1)) : i_a;
  assign w_b_mag = i_b[M-1] ? (~i_b + M'(1)) : i_b;
  assign w_q_fin = r_neg_q ? (~w_q_nx + N'(1)) : w_q_nx;
  assign w_r_fin = r_neg_r ? (~w_rem_nx[M-1:0] + M'(1)) : w_rem_nx[M-1:0];
`else
  assign w_a_mag = i_a;
  assign w_b_mag = i_b;
  assign w_q_fin = w_q_nx;
  assign w_r_fin = w_rem_nx[M-1:0];
`endif

  // The stored remainder is always below D, so its top bit never feeds the next shift.
  assign w_rem_sh         = {r_rem[M-1:0], r_qsh[N-1]};
  assign w_ge             = (w_rem_sh >= {1'b0, r_d});
  assign w_rem_nx         = w_ge ? (w_rem_sh - {1'b0, r_d}) : w_rem_sh;
  assign w_q_nx           = {r_qsh[N-2:0], w_ge};
  assign w_unused_rem_msb = r_rem[M];

  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_qsh   <= '0;
      r_d     <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_q     <= '0;
      o_r     <= '0;
      o_dbz   <= 1'b0;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            if (i_b == '0) begin
              o_q     <= '1;
              o_r     <= i_a[M-1:0];
              o_dbz   <= 1'b1;
              o_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_qsh   <= w_a_mag;
              r_d     <= w_b_mag;
              r_rem   <= '0;
              r_cnt   <= '0;
              o_dbz   <= 1'b0;
              o_busy  <= 1'b1;
              r_state <= StRun;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
              r_neg_q <= i_a[N-1] ^ i_b[M-1];
              r_neg_r <= i_a[N-1];
`endif
            end
          end
        end
        StRun: begin
          r_qsh <= w_q_nx;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == LastCnt) begin
            o_q     <= w_q_fin;
            o_r     <= w_r_fin;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule
